// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_pkg
// Description : Shared state encoding for the perceptron pipe controller.
// Revision    : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/perceptron_vstage.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_vstage
// Description : One pipeline valid bit and its bubble-collapsing enable term.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_vstage (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic d,
  input  logic en_next,
  output logic en,
  output logic v
);

  logic r_v;

  // An empty slot may always load, so bubbles are squeezed out under a stall.
  assign en = !r_v || en_next;
  assign v  = r_v;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_v <= 1'b0;
    end else if (en) begin
      r_v <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/perceptron_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_pipe_ctrl
// Description : Valid/ready stage-enable control with drain/grant weight load.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_pipe_ctrl
  import perceptron_pkg::*;
#(
  parameter  int STAGES = 2,
  parameter  int NW     = 2,
  localparam int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NW-1:0]     w_en_i,
  input  logic              w_req_i,
  output logic              w_gnt_o,
  input  logic              val_i,
  output logic              rdy_o,
  output logic              val_o,
  input  logic              rdy_i,
  output logic [STAGES-1:0] stage_en_o,
  output logic [CNT_W-1:0]  occ_o
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_occ;
  logic [STAGES-1:0]  w_v;
  logic [STAGES-1:0]  w_en;
  logic               w_accept;
  logic               w_emit;
  logic               w_clr;

  assign w_clr    = |w_en_i;
  assign rdy_o    = w_en[0] && (r_state == ST_RUN) && !w_req_i && reset && !w_clr;
  assign w_accept = val_i && rdy_o;
  assign val_o    = w_v[STAGES-1];
  assign w_emit   = val_o && rdy_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic w_d;
    logic w_nx;
    logic w_en_k;

    if (k == 0) begin : g_head
      assign w_d = w_accept;
    end else begin : g_body
      assign w_d = w_v[k-1];
    end

    // The enable chain ripples back from the consumer's ready.
    if (k == STAGES - 1) begin : g_tail
      assign w_nx = rdy_i;
    end else begin : g_link
      assign w_nx = g_stage[k+1].w_en_k;
    end

    perceptron_vstage u_vstage (
      .clk     (clk),
      .reset   (reset),
      .clr     (w_clr),
      .d       (w_d),
      .en_next (w_nx),
      .en      (w_en_k),
      .v       (w_v[k])
    );

    assign w_en[k] = w_en_k;
  end

  assign stage_en_o = (r_state == ST_LOAD) ? '0 : w_en;
  assign w_gnt_o    = (r_state == ST_LOAD);
  assign occ_o      = r_occ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_occ   <= '0;
    end else begin
      if (w_clr) begin
        r_occ <= '0;
      end else if (w_accept && !w_emit) begin
        r_occ <= r_occ + CNT_W'(1);
      end else if (!w_accept && w_emit) begin
        r_occ <= r_occ - CNT_W'(1);
      end

      // An abort takes priority, so a dropped request never yields a grant.
      case (r_state)
        ST_RUN:   if (w_req_i) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!w_req_i)          r_state <= ST_RUN;
          else if (r_occ == '0)  r_state <= ST_LOAD;
        end
        ST_LOAD:  if (!w_req_i) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/perceptron_pipe_ctrl.md
# perceptron_pipe_ctrl

Parametrised valid/ready control path for the perceptron datapath. It generates one register enable per pipeline stage, with bubble collapsing. It tracks occupancy and runs a drain/grant handshake, so weight banks are rewritten only while the pipe is empty. It sits between the upstream sample source and the downstream consumer and drives the enables of a `STAGES`-deep perceptron datapath.

## Interface
- `STAGES`, default 2: number of datapath register stages; must be ≥1.
- `NW`, default 2: number of weight-bank write-enable bits.
- `CNT_W`, localparam `$clog2(STAGES+1)`: occupancy counter width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `w_en_i` in NW: weight-bank write enables; any bit high clears the pipe.
- `w_req_i` in 1: weight-update request; level, held until the update is finished.
- `w_gnt_o` out 1: pipe drained, weights may be written.
- `val_i` in 1: upstream valid.
- `rdy_o` out 1: upstream ready.
- `val_o` out 1: downstream valid.
- `rdy_i` in 1: downstream ready.
- `stage_en_o` out STAGES: datapath register enables; bit 0 is the input stage.
- `occ_o` out CNT_W: number of valid tokens in the pipe.

## Operation
- Per-stage valid bits `v[0..STAGES-1]`.
  - Enable chain: `en[STAGES-1] = !v[STAGES-1] || rdy_i`; `en[k] = !v[k] || en[k+1]`.
  - When `en[k]` is high: `v[0] <= val_i && rdy_o` and `v[k] <= v[k-1]`.
- `val_o = v[STAGES-1]`.
- `stage_en_o = en` masked to zero in LOAD.
- `rdy_o = en[0] && state==RUN && !w_req_i && reset && (w_en_i==0)`.
- `occ_o` counts accepted tokens (`val_i && rdy_o`) minus emitted tokens (`val_o && rdy_i`).
  - Accept and emit in the same cycle leave it unchanged.
  - It always equals popcount(v) and never exceeds `STAGES`.
- FSM states are RUN, DRAIN and LOAD.
  - RUN → DRAIN when `w_req_i=1`.
  - DRAIN → LOAD when `occ_o==0`. This takes at least one DRAIN cycle, even if the pipe is already empty.
  - DRAIN → RUN when `w_req_i` drops before the pipe is empty (abort). Accepting resumes the next cycle.
  - LOAD → RUN when `w_req_i=0`.
- `w_gnt_o = (state==LOAD)`. It is decoded from the state register, not combinational from inputs.
- Any nonzero `w_en_i`, in any state, clears all `v` and `occ_o` at the next edge. The FSM state is unchanged.
  - In LOAD the pipe is already empty, so this is a no-op.
  - In RUN/DRAIN the in-flight tokens are dropped and never presented.
- Reset (`reset=0`) clears `v`, `occ_o`, `val_o` and `w_gnt_o` to 0 and sets the state to RUN. `rdy_o` is 0 during reset.
- Reset mid-DRAIN/LOAD returns to RUN regardless of `w_req_i`. If `w_req_i` is still high, the FSM re-enters DRAIN on the next edge.

## Timing
- Latency: a token accepted at edge t is presented on `val_o` after edge t+STAGES-1, provided no stall occurs.
- Throughput: one token/cycle with `rdy_i=1`.
- On a `rdy_i` stall, upstream keeps accepting until all `STAGES` slots are full (bubble collapse). `rdy_o` then drops in the same cycle.
- Combinational path `rdy_i → en → rdy_o/stage_en_o` is by design; depth grows linearly with `STAGES`.
- `w_req_i` rising forces `rdy_o=0` in the same cycle.
- First `w_gnt_o=1` arrives after edge (edge where occ reaches 0 in DRAIN) + 1.
- `w_en_i` gates `rdy_o` combinationally; its clear takes effect at the next edge.

## Structure
- `perceptron_pkg` holds the state encoding: `ST_RUN=2'd0`, `ST_DRAIN=2'd1`, `ST_LOAD=2'd2`.
- The sub-module `perceptron_vstage` (one valid bit plus its enable term) is natural; it is generated `STAGES` times.
- The FSM and occupancy counter live in the top module.

## Test plan
- Reset: `reset=0` for 2 cycles with `val_i=1` → `rdy_o=0`, `val_o=0`, `occ_o=0`, `w_gnt_o=0`. After release with `rdy_i=1` → `rdy_o=1`.
- Streaming, STAGES=3, `rdy_i=1`, tokens 0..9 back-to-back → first `val_o` 2 cycles after the first accept edge, 10 consecutive outputs in order, `occ_o` steady at 3.
- Bubble collapse, STAGES=3: one token in stage 2, `rdy_i=0` → two more tokens accepted, `occ_o=3`, then `rdy_o=0`. With `rdy_i=1` → order preserved.
- Drain/grant: `occ_o=2`, `w_req_i=1` → `rdy_o=0` the same cycle, 2 emits, `w_gnt_o=1` one cycle after occ reaches 0. `w_en_i=2'b01` pulse → `occ_o` stays 0. `w_req_i=0` → RUN, `rdy_o=1` the next cycle.
- Legacy clear: `occ_o=3` in RUN, `w_en_i=2'b10` for 1 cycle → `rdy_o=0` that cycle, next cycle `occ_o=0` and `val_o=0`, none of the 3 tokens emitted.
- Abort and invariant: `w_req_i` pulsed for 1 cycle in DRAIN with `occ_o=2` → RUN, no grant. Random stimulus → assertion `occ_o==popcount(v) ≤ STAGES` holds throughout.
